// File: rtl/ltl_violation_logger.sv
// Rising-edge logger for one LTL monitor cluster: timestamps property firings,
// queues them in a first-word-fall-through FIFO and keeps sticky/overflow status.
module ltl_violation_logger #(
  parameter int          NUM_PROPS  = 10,
  parameter int          TS_WIDTH   = 32,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [3:0]  CLUSTER_ID = 4'd3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          run,
  input  logic [NUM_PROPS-1:0]          ltl_flags,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [NUM_PROPS-1:0]          evt_prop_mask,
  output logic [TS_WIDTH-1:0]           evt_timestamp,
  output logic [3:0]                    evt_cluster,
  output logic                          evt_dropped,
  output logic [NUM_PROPS-1:0]          sticky_status,
  input  logic [NUM_PROPS-1:0]          sticky_clear,
  output logic                          overflow,
  input  logic                          overflow_clear,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [TS_WIDTH-1:0]  counter_q, counter_d;
  logic [NUM_PROPS-1:0] prev_flags_q, prev_flags_d;
  logic                 drop_pending_q, drop_pending_d;
  logic [NUM_PROPS-1:0] sticky_q, sticky_d;
  logic                 overflow_q, overflow_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;

  // Entry storage carries no reset; occupancy alone decides what is valid.
  logic [NUM_PROPS-1:0] mem_mask_q [FIFO_DEPTH];
  logic [TS_WIDTH-1:0]  mem_ts_q   [FIFO_DEPTH];
  logic                 mem_drop_q [FIFO_DEPTH];

  logic [NUM_PROPS-1:0] rise;
  logic                 push_req, full, pop, accept, drop;

  always_comb begin
    rise     = '0;
    push_req = 1'b0;
    full     = 1'b0;
    pop      = 1'b0;
    accept   = 1'b0;
    drop     = 1'b0;

    if (run) begin
      rise = ltl_flags & ~prev_flags_q;
    end
    push_req = (rise != '0);
    full     = (count_q == CW'(FIFO_DEPTH));
    pop      = evt_valid & evt_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    accept   = push_req & (~full | pop);
    drop     = push_req & full & ~pop;
  end

  always_comb begin
    counter_d      = counter_q;
    prev_flags_d   = '0;
    drop_pending_d = drop_pending_q;
    sticky_d       = (sticky_q & ~sticky_clear) | rise;
    overflow_d     = (overflow_q & ~overflow_clear) | drop;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q + CW'(accept) - CW'(pop);

    if (run) begin
      counter_d    = counter_q + TS_WIDTH'(1);
      prev_flags_d = ltl_flags;
    end
    if (drop) begin
      drop_pending_d = 1'b1;
    end else if (accept) begin
      drop_pending_d = 1'b0;
    end
    if (accept) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      counter_q      <= '0;
      prev_flags_q   <= '0;
      drop_pending_q <= 1'b0;
      sticky_q       <= '0;
      overflow_q     <= 1'b0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
    end else begin
      counter_q      <= counter_d;
      prev_flags_q   <= prev_flags_d;
      drop_pending_q <= drop_pending_d;
      sticky_q       <= sticky_d;
      overflow_q     <= overflow_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && !reset) begin
      mem_mask_q[wr_ptr_q] <= rise;
      mem_ts_q[wr_ptr_q]   <= counter_q;
      mem_drop_q[wr_ptr_q] <= drop_pending_q;
    end
  end

  // Head fields are masked when empty so they read zero out of reset.
  always_comb begin
    evt_valid     = (count_q != '0);
    evt_prop_mask = '0;
    evt_timestamp = '0;
    evt_dropped   = 1'b0;
    if (evt_valid) begin
      evt_prop_mask = mem_mask_q[rd_ptr_q];
      evt_timestamp = mem_ts_q[rd_ptr_q];
      evt_dropped   = mem_drop_q[rd_ptr_q];
    end
  end

  assign evt_cluster   = CLUSTER_ID;
  assign sticky_status = sticky_q;
  assign overflow      = overflow_q;
  assign fifo_count    = count_q;

endmodule

// File: tb/tb_ltl_violation_logger.sv
// Directed bench for ltl_violation_logger: a default build plus a 4-bit
// timestamp build used for counter wrap and reset-discard checks.
module tb_ltl_violation_logger;

  logic        clk;
  logic        reset, run, evt_ready, overflow_clear;
  logic [9:0]  ltl_flags, sticky_clear;
  logic        evt_valid, evt_dropped, overflow;
  logic [9:0]  evt_prop_mask, sticky_status;
  logic [31:0] evt_timestamp;
  logic [3:0]  evt_cluster;
  logic [3:0]  fifo_count;

  logic        s_reset, s_run, s_evt_ready, s_overflow_clear;
  logic [9:0]  s_ltl_flags, s_sticky_clear;
  logic        s_evt_valid, s_evt_dropped, s_overflow;
  logic [9:0]  s_evt_prop_mask, s_sticky_status;
  logic [3:0]  s_evt_timestamp;
  logic [3:0]  s_evt_cluster;
  logic [3:0]  s_fifo_count;

  int checks = 0;
  int errors = 0;

  ltl_violation_logger dut (
    .clk(clk), .reset(reset), .run(run), .ltl_flags(ltl_flags),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_prop_mask(evt_prop_mask),
    .evt_timestamp(evt_timestamp), .evt_cluster(evt_cluster), .evt_dropped(evt_dropped),
    .sticky_status(sticky_status), .sticky_clear(sticky_clear), .overflow(overflow),
    .overflow_clear(overflow_clear), .fifo_count(fifo_count)
  );

  ltl_violation_logger #(.TS_WIDTH(4)) dut4 (
    .clk(clk), .reset(s_reset), .run(s_run), .ltl_flags(s_ltl_flags),
    .evt_valid(s_evt_valid), .evt_ready(s_evt_ready), .evt_prop_mask(s_evt_prop_mask),
    .evt_timestamp(s_evt_timestamp), .evt_cluster(s_evt_cluster), .evt_dropped(s_evt_dropped),
    .sticky_status(s_sticky_status), .sticky_clear(s_sticky_clear), .overflow(s_overflow),
    .overflow_clear(s_overflow_clear), .fifo_count(s_fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  logic [9:0] exp_m [8];

  initial begin
    reset = 1'b1; run = 1'b0; evt_ready = 1'b0; overflow_clear = 1'b0;
    ltl_flags = '0; sticky_clear = '0;
    s_reset = 1'b1; s_run = 1'b0; s_evt_ready = 1'b0; s_overflow_clear = 1'b0;
    s_ltl_flags = '0; s_sticky_clear = '0;
    repeat (3) cyc();

    chk("rst_valid",   32'(evt_valid), 32'd0);
    chk("rst_count",   32'(fifo_count), 32'd0);
    chk("rst_mask",    32'(evt_prop_mask), 32'd0);
    chk("rst_ts",      evt_timestamp, 32'd0);
    chk("rst_dropped", 32'(evt_dropped), 32'd0);
    chk("rst_sticky",  32'(sticky_status), 32'd0);
    chk("rst_ovf",     32'(overflow), 32'd0);
    chk("rst_cluster", 32'(evt_cluster), 32'd3);

    // Test 1: single pulse at counter 5
    reset = 1'b0; run = 1'b1;
    repeat (5) cyc();
    ltl_flags = 10'h004;
    cyc();
    chk("t1_valid",   32'(evt_valid), 32'd1);
    chk("t1_mask",    32'(evt_prop_mask), 32'h004);
    chk("t1_ts",      evt_timestamp, 32'd5);
    chk("t1_dropped", 32'(evt_dropped), 32'd0);
    chk("t1_sticky",  32'(sticky_status), 32'h004);
    chk("t1_count",   32'(fifo_count), 32'd1);
    ltl_flags = '0; evt_ready = 1'b1;
    cyc();
    chk("t1_pop_count", 32'(fifo_count), 32'd0);
    chk("t1_pop_valid", 32'(evt_valid), 32'd0);
    evt_ready = 1'b0;

    // Test 2: held flags, then run gap re-arms edge detection (counter 7 now)
    ltl_flags = 10'h201;
    repeat (4) cyc();
    chk("t2_count1", 32'(fifo_count), 32'd1);
    chk("t2_mask1",  32'(evt_prop_mask), 32'h201);
    chk("t2_ts1",    evt_timestamp, 32'd7);
    chk("t2_sticky", 32'(sticky_status), 32'h205);
    run = 1'b0;
    repeat (3) cyc();
    chk("t2_norun_count", 32'(fifo_count), 32'd1);
    run = 1'b1;
    cyc();
    chk("t2_count2", 32'(fifo_count), 32'd2);
    evt_ready = 1'b1;
    cyc();
    chk("t2_mask2", 32'(evt_prop_mask), 32'h201);
    chk("t2_ts2",   evt_timestamp, 32'd11);
    cyc();
    chk("t2_drain", 32'(fifo_count), 32'd0);
    evt_ready = 1'b0; ltl_flags = '0;
    cyc();

    // Test 3: nine events into an 8-deep FIFO
    for (int k = 0; k < 9; k++) begin
      ltl_flags = 10'(1) << k;
      cyc();
      ltl_flags = '0;
      cyc();
    end
    chk("t3_count",   32'(fifo_count), 32'd8);
    chk("t3_ovf",     32'(overflow), 32'd1);
    chk("t3_sticky",  32'(sticky_status), 32'h3FF);
    chk("t3_head_dr", 32'(evt_dropped), 32'd0);
    evt_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("t3_drain_mask", 32'(evt_prop_mask), 32'(10'(1) << k));
      cyc();
    end
    chk("t3_empty", 32'(fifo_count), 32'd0);
    evt_ready = 1'b0;
    ltl_flags = 10'h008;
    cyc();
    chk("t3_after_mask", 32'(evt_prop_mask), 32'h008);
    chk("t3_after_drop", 32'(evt_dropped), 32'd1);
    ltl_flags = '0;
    cyc();
    ltl_flags = 10'h008;
    cyc();
    chk("t3_count2", 32'(fifo_count), 32'd2);
    ltl_flags = '0; evt_ready = 1'b1;
    cyc();
    chk("t3_next_drop", 32'(evt_dropped), 32'd0);
    chk("t3_next_mask", 32'(evt_prop_mask), 32'h008);
    cyc();
    chk("t3_empty2", 32'(fifo_count), 32'd0);
    evt_ready = 1'b0; overflow_clear = 1'b1;
    cyc();
    chk("t3_ovf_clr", 32'(overflow), 32'd0);
    overflow_clear = 1'b0;

    // Test 4: push and pop together while full
    for (int k = 0; k < 8; k++) begin
      ltl_flags = 10'(1) << k;
      cyc();
      ltl_flags = '0;
      cyc();
    end
    chk("t4_full", 32'(fifo_count), 32'd8);
    evt_ready = 1'b1; ltl_flags = 10'h200;
    cyc();
    ltl_flags = '0;
    chk("t4_count", 32'(fifo_count), 32'd8);
    chk("t4_ovf",   32'(overflow), 32'd0);
    exp_m = '{10'h002, 10'h004, 10'h008, 10'h010, 10'h020, 10'h040, 10'h080, 10'h200};
    for (int k = 0; k < 8; k++) begin
      chk("t4_order", 32'(evt_prop_mask), 32'(exp_m[k]));
      chk("t4_dropped", 32'(evt_dropped), 32'd0);
      cyc();
    end
    chk("t4_empty", 32'(fifo_count), 32'd0);
    evt_ready = 1'b0;

    // Test 5: set-over-clear for sticky and overflow
    sticky_clear = 10'h3FF;
    cyc();
    chk("t5_clr_all", 32'(sticky_status), 32'h000);
    sticky_clear = '0; ltl_flags = 10'h010;
    cyc();
    chk("t5_set", 32'(sticky_status), 32'h010);
    ltl_flags = '0;
    cyc();
    ltl_flags = 10'h010; sticky_clear = 10'h010;
    cyc();
    chk("t5_set_wins", 32'(sticky_status), 32'h010);
    ltl_flags = '0;
    cyc();
    chk("t5_clr_only", 32'(sticky_status), 32'h000);
    sticky_clear = '0;
    for (int k = 0; k < 7; k++) begin
      ltl_flags = 10'h020;
      cyc();
      ltl_flags = '0;
      cyc();
    end
    chk("t5_full", 32'(fifo_count), 32'd8);
    chk("t5_ovf",  32'(overflow), 32'd1);
    ltl_flags = 10'h020; overflow_clear = 1'b1;
    cyc();
    chk("t5_ovf_set_wins", 32'(overflow), 32'd1);
    ltl_flags = '0;
    cyc();
    chk("t5_ovf_clr", 32'(overflow), 32'd0);
    overflow_clear = 1'b0;

    // Reset discards a full queue
    reset = 1'b1;
    cyc();
    chk("t5_rst_valid", 32'(evt_valid), 32'd0);
    chk("t5_rst_count", 32'(fifo_count), 32'd0);
    reset = 1'b0;

    // Test 6: 4-bit counter wrap, then reset with 3 queued entries
    s_reset = 1'b0; s_run = 1'b1;
    repeat (15) cyc();
    s_ltl_flags = 10'h001;
    cyc();
    chk("t6_ts15", 32'(s_evt_timestamp), 32'd15);
    s_ltl_flags = 10'h002;
    cyc();
    s_ltl_flags = 10'h004;
    cyc();
    s_ltl_flags = '0;
    chk("t6_count3", 32'(s_fifo_count), 32'd3);
    chk("t6_head_mask", 32'(s_evt_prop_mask), 32'h001);
    s_evt_ready = 1'b1;
    cyc();
    chk("t6_ts0", 32'(s_evt_timestamp), 32'd0);
    chk("t6_mask0", 32'(s_evt_prop_mask), 32'h002);
    s_evt_ready = 1'b0;
    s_ltl_flags = 10'h008;
    cyc();
    s_ltl_flags = '0;
    chk("t6_count_b", 32'(s_fifo_count), 32'd3);
    s_reset = 1'b1;
    cyc();
    chk("t6_rst_valid",   32'(s_evt_valid), 32'd0);
    chk("t6_rst_count",   32'(s_fifo_count), 32'd0);
    chk("t6_rst_ts",      32'(s_evt_timestamp), 32'd0);
    chk("t6_rst_cluster", 32'(s_evt_cluster), 32'd3);
    s_reset = 1'b0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
